// File: rtl/clock_divider_pkg.sv
// clock_divider_pkg
// Shared width and type definitions for the counter-based clock divider.
// Configuration macro: CLKDIV_DIV32_EN widens the counter to 5 bits so the
// divide-by-32 output can be produced; otherwise the counter is 4 bits.
package clock_divider_pkg;

  localparam int unsigned CNT_W_BASE = 4;

`ifdef CLKDIV_DIV32_EN
  localparam int unsigned CNT_W = CNT_W_BASE + 1;
`else
  localparam int unsigned CNT_W = CNT_W_BASE;
`endif

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/clkdiv_counter.sv
// clkdiv_counter
// Free-running binary up-counter of width CNT_W with asynchronous reset.
// It wraps from all-ones to zero with no stall.
// Ports:
//   clk   - counting clock, rising edge
//   reset - asynchronous, active-high clear
//   cnt   - current count (registered)
// Width follows CLKDIV_DIV32_EN through clock_divider_pkg.
module clkdiv_counter
  import clock_divider_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output cnt_t cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + cnt_t'(1);
    end
  end

endmodule

// File: rtl/clock_divider_count.sv
// clock_divider_count
// Divide-by-2/4/8/16 (and optionally /32) clock strobes taken directly from
// the bits of a single up-counter, so every output is a flop output with a
// 50 % duty cycle and all edges aligned to rising clk.
// Ports:
//   clk        - input clock
//   reset      - asynchronous, active-high; forces all outputs to 0
//   divideby2  - clk / 2
//   divideby4  - clk / 4
//   divideby8  - clk / 8
//   divideby16 - clk / 16
//   divideby32 - clk / 32, present only when CLKDIV_DIV32_EN is defined
module clock_divider_count
  import clock_divider_pkg::*;
(
  input  logic clk,
  input  logic reset,
  output logic divideby2,
  output logic divideby4,
  output logic divideby8,
  output logic divideby16
`ifdef CLKDIV_DIV32_EN
  ,
  output logic divideby32
`endif
);

  cnt_t cnt;

  clkdiv_counter u_counter (
    .clk   (clk),
    .reset (reset),
    .cnt   (cnt)
  );

  // Pure wiring: the ports are the counter flops themselves.
  assign divideby2  = cnt[0];
  assign divideby4  = cnt[1];
  assign divideby8  = cnt[2];
  assign divideby16 = cnt[3];
`ifdef CLKDIV_DIV32_EN
  assign divideby32 = cnt[4];
`endif

endmodule

// File: tb/tb_clock_divider_count.sv
// tb_clock_divider_count
// Self-checking bench for clock_divider_count. The reference model counts
// rising edges since reset release and derives each output from the
// divider's half-period rule. Honours CLKDIV_DIV32_EN.
module tb_clock_divider_count;

`ifdef CLKDIV_DIV32_EN
  localparam int unsigned NOUT = 5;
`else
  localparam int unsigned NOUT = 4;
`endif

  logic clk;
  logic reset;
  logic divideby2;
  logic divideby4;
  logic divideby8;
  logic divideby16;
  logic divideby32;

  int unsigned n_cmp;
  int unsigned n_err;
  int unsigned edges;

  clock_divider_count dut (
    .clk        (clk),
    .reset      (reset),
    .divideby2  (divideby2),
    .divideby4  (divideby4),
    .divideby8  (divideby8),
    .divideby16 (divideby16)
`ifdef CLKDIV_DIV32_EN
    ,
    .divideby32 (divideby32)
`endif
  );

`ifndef CLKDIV_DIV32_EN
  assign divideby32 = 1'b0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Output index k is clk / 2^(k+1): high during the second half of each
  // 2^(k+1)-edge period counted from reset release.
  function automatic logic [4:0] model(input int unsigned e);
    logic [4:0] r;
    int unsigned period;
    r = '0;
    for (int unsigned k = 0; k < NOUT; k++) begin
      period = 2 ** (k + 1);
      r[k] = (e % period) >= (period / 2);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {divideby32, divideby16, divideby8, divideby4, divideby2};
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!reset) edges++;
    #1;
    check(tag, model(edges));
  endtask

  initial begin
    int unsigned guard;
    n_cmp = 0;
    n_err = 0;
    edges = 0;
    reset = 1'b1;

    // Reset held 0..14: outputs 0, including across the 5 ns edge.
    #1;
    check("reset_t1", 5'b0);
    @(posedge clk);
    #1;
    check("reset_edge5", 5'b0);
    #8;
    reset = 1'b0;               // t = 14

    step("first_edge");         // t = 16, expect divideby2 only
    check("first_edge_const", 5'b00001);
    step("second_edge");        // t = 26
    check("second_edge_const", 5'b00010);

    // Continue through the first wrap (16th edge at 165).
    for (int i = 3; i <= 16; i++) begin
      step("run_to_wrap");
      if (i == 15) check("all_high_pre_wrap", model(15));
    end
`ifndef CLKDIV_DIV32_EN
    check("wrap_all_zero", 5'b0);
`endif

    // Run to count 0b1011, then reset between edges.
    guard = 0;
    while ((edges % (2 ** NOUT)) != 11 && guard < 64) begin
      step("seek_1011");
      guard++;
    end
    n_cmp++;
    assert (guard < 64)
    else begin
      n_err++;
      $error("FAIL seek_1011_timeout: observed %0d expected <64", guard);
    end
    check("at_1011", model(11));
    #3;
    reset = 1'b1;
    edges = 0;
    #1;
    check("async_reset_mid_cycle", 5'b0);
    step("held_reset");
    @(negedge clk);
    reset = 1'b0;
    step("restart_from_1");
    step("restart_2");

    // Randomized run lengths and asynchronous reset pulses.
    for (int it = 0; it < 20; it++) begin
      int unsigned run_len;
      run_len = $urandom_range(40, 1);
      for (int unsigned c = 0; c < run_len; c++) step("rand_run");
      @(posedge clk);
      if (!reset) edges++;
      #($urandom_range(8, 2));
      reset = 1'b1;
      edges = 0;
      #1;
      check("rand_async_reset", 5'b0);
      repeat ($urandom_range(3, 0)) step("rand_reset_hold");
      @(posedge clk);
      #($urandom_range(8, 2));
      reset = 1'b0;
      step("rand_release_first");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
